// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: edge-detects peripheral completions, masks, arbitrates, and
// hands one vector at a time to the core. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module irq_vector_ctrl #(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] done,
    input  logic               int_en,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wd,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [31:0]        int_addr,
    output logic [2:0]         int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               busy
);

    localparam int unsigned IdW = 3;

    typedef enum logic [1:0] {StIdle, StReq, StService} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] done_d_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [IdW-1:0]     id_q;
    logic [31:0]        addr_q;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [IdW-1:0]     win_id;
    logic               win_found;
    logic [31:0]        win_addr;
    logic               take_sel;
    logic               take_ack;
    logic               take_ret;

    assign evt      = done & ~done_d_q;
    assign eligible = pending_q & mask_q;
    assign take_sel = (state_q == StIdle) && int_en && win_found;
    // Ack wins over a simultaneous return, so int_ret only counts in SERVICE.
    assign take_ack = (state_q == StReq) && int_ack;
    assign take_ret = (state_q == StService) && int_ret;
    assign win_addr = VEC_BASE + VEC_STRIDE * {{(32 - IdW){1'b0}}, win_id};

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IdW-1:0] last_q;
    logic [IdW-1:0] start;

    assign start = (last_q == IdW'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= IdW'(NUM_SRC - 1);
        end else if (take_ack) begin
            last_q <= id_q;
        end
    end

    // Search eligible sources starting at the one after the last serviced.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            for (int j = 0; j < int'(NUM_SRC); j++) begin
                if (!win_found && eligible[j] && (j == (int'(start) + k) % int'(NUM_SRC))) begin
                    win_id    = IdW'(j);
                    win_found = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            if (!win_found && eligible[j]) begin
                win_id    = IdW'(j);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clr[i] = take_ack && (id_q == IdW'(i));
        end
        // A new event in the clearing cycle must survive.
        pending_d = (pending_q & ~clr) | evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_d_q  <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            id_q      <= '0;
            addr_q    <= '0;
        end else begin
            done_d_q  <= done;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wd;
            end
            if (take_sel) begin
                id_q   <= win_id;
                addr_q <= win_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (take_sel) state_d = StReq;
            StReq:     if (take_ack) state_d = StService;
            StService: if (take_ret) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        int_req  = (state_q == StReq);
        busy     = (state_q != StIdle);
        int_id   = id_q;
        int_addr = addr_q;
        pending  = pending_q;
        mask     = mask_q;
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Scoreboard bench for irq_vector_ctrl: stimulus pushes expected vectors, a monitor checks each
// new request against the queue. Expectations follow IRQ_ROUND_ROBIN_EN when defined.
module tb_irq_vector_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  done;
    logic        int_en;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        int_ack;
    logic        int_ret;
    logic        int_req;
    logic [31:0] int_addr;
    logic [2:0]  int_id;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic        busy;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic req_prev = 1'b0;

    irq_vector_ctrl #(
        .NUM_SRC(4),
        .VEC_BASE(32'h0000_0180),
        .VEC_STRIDE(32'h0000_0010)
    ) dut (
        .clk(clk),
        .reset(reset),
        .done(done),
        .int_en(int_en),
        .mask_we(mask_we),
        .mask_wd(mask_wd),
        .int_ack(int_ack),
        .int_ret(int_ret),
        .int_req(int_req),
        .int_addr(int_addr),
        .int_id(int_id),
        .pending(pending),
        .mask(mask),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every fresh request is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (int_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got id %0d addr %0h expected none", int_id, int_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("req_id", {29'b0, int_id}, {29'b0, e.id});
                check("req_addr", int_addr, e.addr);
            end
        end
        req_prev <= int_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [2:0] id, input logic [31:0] addr);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic pulse_done(input logic [3:0] v);
        done = v;
        tick();
        done = '0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!int_req && n < 20) begin
            tick();
            n++;
        end
        if (!int_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got int_req 0 expected 1");
        end
    endtask

    task automatic ack_ret();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("svc_busy", {31'b0, busy}, 32'd1);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check("ret_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        done    = '0;
        int_en  = 1'b1;
        mask_we = 1'b0;
        mask_wd = '0;
        int_ack = 1'b0;
        int_ret = 1'b0;
        do_reset();
        check("rst_req", {31'b0, int_req}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_pending", {28'b0, pending}, 32'h0);
        check("rst_mask", {28'b0, mask}, 32'hF);
        check("rst_addr", int_addr, 32'h0);
        check("rst_id", {29'b0, int_id}, 32'd0);

        // Single source 2.
        expect_req(3'd2, 32'h1A0);
        pulse_done(4'b0100);
        check("single_pend", {28'b0, pending}, 32'h4);
        wait_req();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("single_pend_clr", {28'b0, pending}, 32'h0);
        check("single_svc_req", {31'b0, int_req}, 32'd0);
        check("single_svc_id", {29'b0, int_id}, 32'd2);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check("single_idle", {31'b0, busy}, 32'd0);

        // Reset mid-SERVICE with a fresh pending event and a modified mask.
        expect_req(3'd3, 32'h1B0);
        pulse_done(4'b1000);
        wait_req();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        pulse_done(4'b0001);
        mask_we = 1'b1;
        mask_wd = 4'b0111;
        tick();
        mask_we = 1'b0;
        check("svc_pend", {28'b0, pending}, 32'h1);
        reset = 1'b1;
        tick();
        check("mid_rst_req", {31'b0, int_req}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_pend", {28'b0, pending}, 32'h0);
        check("mid_rst_mask", {28'b0, mask}, 32'hF);
        check("mid_rst_addr", int_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Simultaneous 1 and 3.
        expect_req(3'd1, 32'h190);
        expect_req(3'd3, 32'h1B0);
        pulse_done(4'b1010);
        wait_req();
        ack_ret();
        wait_req();
        ack_ret();

        // Masked source stays pending until unmasked.
        mask_we = 1'b1;
        mask_wd = 4'b1110;
        tick();
        mask_we = 1'b0;
        pulse_done(4'b0001);
        tick();
        tick();
        tick();
        check("masked_req", {31'b0, int_req}, 32'd0);
        check("masked_pend", {28'b0, pending}, 32'h1);
        expect_req(3'd0, 32'h180);
        mask_we = 1'b1;
        mask_wd = 4'b1111;
        tick();
        mask_we = 1'b0;
        wait_req();
        ack_ret();

        // Global enable low blocks requests.
        int_en = 1'b0;
        pulse_done(4'b0100);
        tick();
        tick();
        tick();
        check("dis_req", {31'b0, int_req}, 32'd0);
        check("dis_pend", {28'b0, pending}, 32'h4);
        expect_req(3'd2, 32'h1A0);
        int_en = 1'b1;
        wait_req();
        ack_ret();

        // Set-vs-clear race on source 1.
        expect_req(3'd1, 32'h190);
        pulse_done(4'b0010);
        wait_req();
        done    = 4'b0010;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        done    = '0;
        check("race_pend", {28'b0, pending}, 32'h2);
        expect_req(3'd1, 32'h190);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        wait_req();
        ack_ret();
        check("race_done_pend", {28'b0, pending}, 32'h0);

        // Priority order with source 0 re-raised at every ack.
        do_reset();
`ifdef IRQ_ROUND_ROBIN_EN
        expect_req(3'd0, 32'h180);
        expect_req(3'd1, 32'h190);
        expect_req(3'd2, 32'h1A0);
        expect_req(3'd3, 32'h1B0);
        expect_req(3'd0, 32'h180);
`else
        for (int i = 0; i < 5; i++) expect_req(3'd0, 32'h180);
`endif
        pulse_done(4'b1111);
        for (int i = 0; i < 5; i++) begin
            wait_req();
            done    = 4'b0001;
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
            done    = '0;
            if (i < 4) begin
                int_ret = 1'b1;
                tick();
                int_ret = 1'b0;
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
